// File: rtl/mul_pkg.sv
// Shared constants and FSM encoding for the
// multiplier arbiter slice.
package mul_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int N_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESPOND
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after
// last_grant, wrapping modulo N.
module rr_arbiter
  import mul_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          any
);

  logic [IW-1:0] idx;

  // scan last_grant+1 .. last_grant+N, keep the first hit
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = last_grant + IW'(i);
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multiplier among N requesters,
// one operation in flight, round-robin grant.
module mul_arbiter
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_a,
  input  logic [N*WIDTH-1:0]   req_b,
  output logic [N-1:0]         req_accept,
  output logic [N-1:0]         rsp_done,
  output logic [2*WIDTH-1:0]   rsp_product,
  input  logic [N-1:0]         rsp_ack,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_valid,
  input  logic                 mul_ret_ack,
  input  logic                 mul_done,
  input  logic [2*WIDTH-1:0]   mul_product,
  output logic                 mul_ack,
  output logic [15:0]          ops_count
);

  localparam int IW = $clog2(N);

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] grant;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] pick;
  logic          any;
  logic          ack_hit;
  logic [N-1:0]  grant_oh;

  rr_arbiter #(.N(N)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick),
    .any        (any)
  );

  assign ack_hit  = rsp_ack[grant];
  assign grant_oh = N'(1) << grant;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and state-decoded handshake outputs
  always_comb begin
    state_nx  = state;
    mul_valid = 1'b0;
    rsp_done  = '0;
    unique case (state)
      IDLE: begin
        if (any) state_nx = ISSUE;
      end
      ISSUE: begin
        mul_valid = 1'b1;
        if (mul_ret_ack) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mul_done) state_nx = RESPOND;
      end
      RESPOND: begin
        rsp_done = grant_oh;
        if (ack_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // operand latch, result capture, bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      last_grant  <= IW'(N - 1);
      mul_a       <= '0;
      mul_b       <= '0;
      req_accept  <= '0;
      mul_ack     <= 1'b0;
      rsp_product <= '0;
      ops_count   <= '0;
    end else begin
      req_accept <= '0;
      mul_ack    <= 1'b0;
      if (state == IDLE && any) begin
        grant      <= pick;
        mul_a      <= req_a[pick*WIDTH +: WIDTH];
        mul_b      <= req_b[pick*WIDTH +: WIDTH];
        req_accept <= N'(1) << pick;
      end
      if (state == WAIT_DONE && mul_done) begin
        rsp_product <= mul_product;
        mul_ack     <= 1'b1;
      end
      if (state == RESPOND && ack_hit) begin
        last_grant <= grant;
        if (ops_count != 16'hFFFF)
          ops_count <= ops_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter with a behavioural
// multiplicador sharing the same reset.
module tb_mul_arbiter;
  import mul_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_accept;
  logic [N-1:0]     rsp_done;
  logic [2*W-1:0]   rsp_product;
  logic [N-1:0]     rsp_ack;
  logic [W-1:0]     mul_a;
  logic [W-1:0]     mul_b;
  logic             mul_valid;
  logic             mul_ret_ack;
  logic             mul_done;
  logic [2*W-1:0]   mul_product;
  logic             mul_ack;
  logic [15:0]      ops_count;

  int tests = 0;
  int fails = 0;
  int exp_ops = 0;
  int last = N - 1;
  int mlat = 2;

  logic stray_ret = 1'b0;
  logic stray_done = 1'b0;

  logic           m_ret;
  logic           m_done;
  logic           m_busy;
  int             m_cnt;
  logic [W-1:0]   m_a;
  logic [W-1:0]   m_b;
  logic [2*W-1:0] m_prod;

  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];

  mul_arbiter #(.WIDTH(W), .N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_accept  (req_accept),
    .rsp_done    (rsp_done),
    .rsp_product (rsp_product),
    .rsp_ack     (rsp_ack),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_valid   (mul_valid),
    .mul_ret_ack (mul_ret_ack),
    .mul_done    (mul_done),
    .mul_product (mul_product),
    .mul_ack     (mul_ack),
    .ops_count   (ops_count)
  );

  always #5 clk = ~clk;

  assign mul_ret_ack = m_ret | stray_ret;
  assign mul_done    = m_done | stray_done;
  assign mul_product = m_prod;

  // multiplicador: accept, wait mlat cycles, hold done until ack
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ret  <= 1'b0;
      m_done <= 1'b0;
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_a    <= '0;
      m_b    <= '0;
      m_prod <= '0;
    end else begin
      m_ret <= 1'b0;
      if (!m_busy && mul_valid && !m_ret) begin
        m_busy <= 1'b1;
        m_ret  <= 1'b1;
        m_cnt  <= mlat;
        m_a    <= mul_a;
        m_b    <= mul_b;
      end else if (m_busy && !m_done) begin
        if (m_cnt == 0) begin
          m_done <= 1'b1;
          m_prod <= 64'(m_a) * 64'(m_b);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (m_done && mul_ack) begin
        m_done <= 1'b0;
        m_busy <= 1'b0;
      end
    end
  end

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    pa[i] = a;
    pb[i] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic accept_step(input int g,
                             input string tag);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (req_accept == '0 && c < 200);
    chk({tag, ":accept"}, 64'(req_accept), 64'(oh(g)));
    req_valid[g] = 1'b0;
  endtask

  task automatic done_step(input int g,
                           input logic [63:0] p,
                           input string tag);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (rsp_done == '0 && c < 200);
    chk({tag, ":done"}, 64'(rsp_done), 64'(oh(g)));
    chk({tag, ":prod"}, rsp_product, p);
    chk({tag, ":mack"}, 64'(mul_ack), 64'd1);
  endtask

  task automatic ack_step(input int g,
                          input int dly,
                          input string tag);
    repeat (dly) @(negedge clk);
    rsp_ack[g] = 1'b1;
    @(negedge clk);
    rsp_ack[g] = 1'b0;
    exp_ops++;
    if (exp_ops > 65535) exp_ops = 65535;
    chk({tag, ":ops"}, 64'(ops_count), 64'(exp_ops));
    chk({tag, ":clr"}, 64'({rsp_done, mul_ack}), 64'd0);
    last = g;
  endtask

  task automatic serve(input int g,
                       input logic [63:0] p,
                       input int dly,
                       input string tag);
    accept_step(g, tag);
    done_step(g, p, tag);
    ack_step(g, dly, tag);
  endtask

  initial begin
    int c;
    int g;
    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ack   = '0;
    #1;
    chk("rst:ctl", 64'({req_accept, rsp_done,
        mul_valid, mul_ack, ops_count}), 64'd0);
    chk("rst:prod", rsp_product, 64'd0);
    chk("rst:ops", 64'({mul_a, mul_b}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    @(negedge clk);
    stray_ret  = 1'b1;
    stray_done = 1'b1;
    @(negedge clk);
    stray_ret  = 1'b0;
    stray_done = 1'b0;
    @(negedge clk);
    chk("stray", 64'({req_accept, rsp_done,
        mul_valid, mul_ack, ops_count}), 64'd0);

    set_req(0, 150, 2);
    @(negedge clk);
    c = 1;
    chk("single:lat", 64'(req_accept), 64'(oh(0)));
    req_valid[0] = 1'b0;
    done_step(0, 64'd300, "single");
    ack_step(0, 1, "single");

    set_req(2, 11, 13);
    set_req(3, 4, 5);
    accept_step(2, "hold");
    done_step(2, 64'd143, "hold");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hold:stable", 64'({rsp_done, req_accept,
          mul_ack}), 64'({oh(2), 4'b0, 1'b0}));
      chk("hold:prod", rsp_product, 64'd143);
    end
    ack_step(2, 0, "hold");
    serve(3, 64'd20, 0, "hold3");

    set_req(0, 700, 1250);
    set_req(1, 3, 5);
    set_req(2, 7, 9);
    set_req(3, 0, 12345);
    serve(0, 64'd875000, 0, "all0");
    serve(1, 64'd15, 0, "all1");
    serve(2, 64'd63, 0, "all2");
    serve(3, 64'd0, 0, "all3");

    set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    serve(0, 64'hFFFF_FFFE_0000_0001, 0, "max");

    set_req(1, 1234, 5678);
    accept_step(1, "stray3");
    req_a[W +: W] = 999;
    req_b[W +: W] = 77;
    done_step(1, 64'd7006652, "stray3");
    rsp_ack[3] = 1'b1;
    @(negedge clk);
    rsp_ack[3] = 1'b0;
    chk("stray3:keep", 64'(rsp_done), 64'(oh(1)));
    chk("stray3:ops", 64'(ops_count), 64'(exp_ops));
    ack_step(1, 0, "stray3");

    mlat = 12;
    set_req(0, 21, 2);
    set_req(1, 6, 7);
    accept_step(0, "rstmid");
    repeat (3) @(negedge clk);
    chk("rstmid:wait", 64'({mul_valid, rsp_done}), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid:ctl", 64'({req_accept, rsp_done,
        mul_valid, mul_ack, ops_count}), 64'd0);
    chk("rstmid:prod", rsp_product, 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid:hold", 64'(req_accept), 64'd0);
    reset = 1'b1;
    exp_ops = 0;
    last = N - 1;
    mlat = 2;
    serve(1, 64'd42, 0, "rstmid1");

    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, $urandom(), $urandom());
      end
      if (req_valid == '0)
        set_req($urandom_range(0, N - 1),
                $urandom(), $urandom());
      mlat = $urandom_range(0, 4);
      g = -1;
      for (int k = 1; k <= N; k++) begin
        if (g < 0 && req_valid[(last + k) % N])
          g = (last + k) % N;
      end
      serve(g, 64'(pa[g]) * 64'(pb[g]),
            $urandom_range(0, 3), "rand");
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
